// File: rtl/sdf_r2_stage_if.sv
// Streaming port bundle for one radix-2 SDF stage: sample stream in, butterfly stream out.
// Handshake: no back-pressure. A beat transfers on every rising clk edge where valid is 1;
// sof and data are only meaningful in that cycle, and the sink must always accept.
interface sdf_r2_stage_if #(
  parameter int WIDTH = 17
);
  logic             in_valid;
  logic             in_sof;
  logic [WIDTH-1:0] in_re;
  logic [WIDTH-1:0] in_im;
  logic             out_valid;
  logic             out_sof;
  logic [WIDTH-1:0] out_re;
  logic [WIDTH-1:0] out_im;

  modport master (
    output in_valid, in_sof, in_re, in_im,
    input  out_valid, out_sof, out_re, out_im
  );

  modport slave (
    input  in_valid, in_sof, in_re, in_im,
    output out_valid, out_sof, out_re, out_im
  );
endinterface

// File: rtl/sdf_r2_stage.sv
// Radix-2 single-path delay-feedback butterfly stage (DIF). The first half of each
// 2*DEPTH span fills the delay line; the second half emits sums and feeds back differences.
module sdf_r2_stage #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 32,
  parameter int SCALE = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  sdf_r2_stage_if.slave  s
);

  localparam int CW = $clog2(DEPTH) + 1;
  // cnt == DEPTH is the first phase-1 sample (phase bit set, idx 0); valid for DEPTH == 1 too.
  localparam logic [CW-1:0] SOF_CNT = CW'(DEPTH);
  localparam logic signed [WIDTH+1:0] ONE = 1;

  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_eff;
  logic             primed;
  logic             primed_eff;
  logic             phase;
  logic [WIDTH-1:0] dl_re [DEPTH];
  logic [WIDTH-1:0] dl_im [DEPTH];
  logic [WIDTH-1:0] sum_re;
  logic [WIDTH-1:0] sum_im;
  logic [WIDTH-1:0] dif_re;
  logic [WIDTH-1:0] dif_im;

  // Two guard bits keep the rounding add exact before the result is cut back to WIDTH.
  function automatic logic [WIDTH-1:0] bfly(input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic             sub);
    logic signed [WIDTH+1:0] ae;
    logic signed [WIDTH+1:0] be;
    logic signed [WIDTH+1:0] v;
    ae = signed'({{2{a[WIDTH-1]}}, a});
    be = signed'({{2{b[WIDTH-1]}}, b});
    v  = sub ? (ae - be) : (ae + be);
    if (SCALE != 0) v = (v + ONE) >>> 1;
    return v[WIDTH-1:0];
  endfunction

  always_comb begin
    cnt_eff    = s.in_sof ? '0 : cnt;
    phase      = cnt_eff[CW-1];
    // A sof that lands mid-span means the delay line holds a torn frame: re-prime.
    primed_eff = primed & ~(s.in_sof & (cnt != '0));
    sum_re     = bfly(dl_re[DEPTH-1], s.in_re, 1'b0);
    sum_im     = bfly(dl_im[DEPTH-1], s.in_im, 1'b0);
    dif_re     = bfly(dl_re[DEPTH-1], s.in_re, 1'b1);
    dif_im     = bfly(dl_im[DEPTH-1], s.in_im, 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      primed      <= 1'b0;
      s.out_valid <= 1'b0;
      s.out_sof   <= 1'b0;
      s.out_re    <= '0;
      s.out_im    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dl_re[i] <= '0;
        dl_im[i] <= '0;
      end
    end else begin
      s.out_valid <= s.in_valid & (primed_eff | phase);
      s.out_sof   <= s.in_valid & (cnt_eff == SOF_CNT);
      if (s.in_valid) begin
        cnt    <= cnt_eff + CW'(1);
        primed <= primed_eff | phase;
        for (int i = 1; i < DEPTH; i++) begin
          dl_re[i] <= dl_re[i-1];
          dl_im[i] <= dl_im[i-1];
        end
        dl_re[0] <= phase ? dif_re : s.in_re;
        dl_im[0] <= phase ? dif_im : s.in_im;
        s.out_re <= phase ? sum_re : dl_re[DEPTH-1];
        s.out_im <= phase ? sum_im : dl_im[DEPTH-1];
      end
    end
  end

endmodule

// File: tb/tb_sdf_r2_stage.sv
// Bench for sdf_r2_stage: DUT A (DEPTH=4, full scale) and DUT B (DEPTH=1, halving) share
// one stimulus stream and are each checked against a frame-level butterfly model.
module tb_sdf_r2_stage;
  localparam int W = 17;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sdf_r2_stage_if #(.WIDTH(W)) ifa ();
  sdf_r2_stage_if #(.WIDTH(W)) ifb ();

  sdf_r2_stage #(.WIDTH(W), .DEPTH(4), .SCALE(0)) dut_a (.clk(clk), .rst_n(rst_n), .s(ifa.slave));
  sdf_r2_stage #(.WIDTH(W), .DEPTH(1), .SCALE(1)) dut_b (.clk(clk), .rst_n(rst_n), .s(ifb.slave));

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Per stage: a span is 2*dep samples; the first half is stored, the second half pairs
  // with it (sum out now, difference out during the next span's first half).
  int  dep [2] = '{4, 1};
  bit  scl [2] = '{1'b0, 1'b1};
  int  pos [2];
  bit  primed [2];
  int  fh_re [2][4];
  int  fh_im [2][4];
  int  pd_re [2][4];
  int  pd_im [2][4];
  bit  exp_v [2];
  logic [2*W:0] exp_qa [$];
  logic [2*W:0] exp_qb [$];
  logic [W-1:0] cap_q [$];
  bit  cap = 1'b0;

  function automatic int sx(input logic [W-1:0] v);
    return int'($signed(v));
  endfunction

  function automatic logic [W-1:0] bf(input int d, input int x, input bit sub, input bit scale);
    int v;
    v = sub ? d - x : d + x;
    if (scale) v = (v + 1) >>> 1;
    return W'(v);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      pos[i] = 0;
      primed[i] = 1'b0;
      exp_v[i] = 1'b0;
      for (int k = 0; k < 4; k++) begin
        fh_re[i][k] = 0; fh_im[i][k] = 0; pd_re[i][k] = 0; pd_im[i][k] = 0;
      end
    end
    exp_qa.delete();
    exp_qb.delete();
  endtask

  task automatic model_accept(input int i, input bit sof, input logic [W-1:0] xr,
                              input logic [W-1:0] xi);
    int k;
    logic [2*W:0] e;
    if (sof) begin
      if (pos[i] != 0) primed[i] = 1'b0;
      pos[i] = 0;
    end
    if (pos[i] < dep[i]) begin
      exp_v[i] = primed[i];
      e = {1'b0, W'(pd_re[i][pos[i]]), W'(pd_im[i][pos[i]])};
      fh_re[i][pos[i]] = sx(xr);
      fh_im[i][pos[i]] = sx(xi);
    end else begin
      k = pos[i] - dep[i];
      exp_v[i] = 1'b1;
      e = {(k == 0), bf(fh_re[i][k], sx(xr), 1'b0, scl[i]), bf(fh_im[i][k], sx(xi), 1'b0, scl[i])};
      pd_re[i][k] = sx(bf(fh_re[i][k], sx(xr), 1'b1, scl[i]));
      pd_im[i][k] = sx(bf(fh_im[i][k], sx(xi), 1'b1, scl[i]));
      primed[i] = 1'b1;
    end
    pos[i] = (pos[i] + 1) % (2 * dep[i]);
    if (exp_v[i]) begin
      if (i == 0) exp_qa.push_back(e);
      else        exp_qb.push_back(e);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input int i);
    logic v, s;
    logic [W-1:0] r, m;
    logic [2*W:0] e;
    if (i == 0) begin v = ifa.out_valid; s = ifa.out_sof; r = ifa.out_re; m = ifa.out_im; end
    else        begin v = ifb.out_valid; s = ifb.out_sof; r = ifb.out_re; m = ifb.out_im; end
    check($sformatf("out_valid[%0d]", i), 64'(v), 64'(exp_v[i]));
    if (exp_v[i]) begin
      if (i == 0) e = exp_qa.pop_front();
      else        e = exp_qb.pop_front();
      check($sformatf("out_sof[%0d]", i), 64'(s), 64'(e[2*W]));
      check($sformatf("out_re[%0d]", i), 64'(r), 64'(e[2*W-1:W]));
      check($sformatf("out_im[%0d]", i), 64'(m), 64'(e[W-1:0]));
    end
    if (i == 0 && cap && v) cap_q.push_back(r);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_a"}, 64'({ifa.out_valid, ifa.out_sof, ifa.out_re, ifa.out_im}), 64'(0));
    check({tag, "_b"}, 64'({ifb.out_valid, ifb.out_sof, ifb.out_re, ifb.out_im}), 64'(0));
  endtask

  // ---------------- drivers ----------------
  // Called just after a falling edge; returns just after the next falling edge.
  task automatic step(input bit v, input bit sof, input logic [W-1:0] r, input logic [W-1:0] m);
    ifa.in_valid = v; ifa.in_sof = sof; ifa.in_re = r; ifa.in_im = m;
    ifb.in_valid = v; ifb.in_sof = sof; ifb.in_re = r; ifb.in_im = m;
    if (v) begin
      model_accept(0, sof, r, m);
      model_accept(1, sof, r, m);
    end else begin
      exp_v[0] = 1'b0;
      exp_v[1] = 1'b0;
    end
    @(posedge clk);
    #1;
    check_out(0);
    check_out(1);
    @(negedge clk);
  endtask

  task automatic send_seq(input int re_s[$], input int im_s[$], input bit sof_s[$], input bit stall);
    for (int n = 0; n < re_s.size(); n++) begin
      if (stall) while ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, '0, '0);
      step(1'b1, sof_s[n], W'(re_s[n]), W'(im_s[n]));
    end
  endtask

  task automatic pulse_reset(input bit check_async);
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    if (check_async) check_zero("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Test-2 frame pair: real 1..8 then eight zeros, sof on each frame start.
  task automatic basic_pair(input bit stall);
    int re_s[$]; int im_s[$]; bit sof_s[$];
    for (int n = 0; n < 16; n++) begin
      re_s.push_back(n < 8 ? n + 1 : 0);
      im_s.push_back(n < 8 ? -(n + 1) : 0);
      sof_s.push_back(n == 0 || n == 8);
    end
    send_seq(re_s, im_s, sof_s, stall);
  endtask

  task automatic check_basic_capture(input string tag);
    int golden[12] = '{6, 8, 10, 12, -4, -4, -4, -4, 0, 0, 0, 0};
    logic [W-1:0] g;
    check({tag, "_count"}, 64'(cap_q.size()), 64'(12));
    for (int n = 0; n < 12 && n < cap_q.size(); n++) begin
      g = W'(golden[n]);
      check($sformatf("%s_re%0d", tag, n), 64'(cap_q[n]), 64'(g));
    end
  endtask

  // ---------------- main ----------------
  initial begin
    int re_s[$]; int im_s[$]; bit sof_s[$];
    logic [W-1:0] g;
    ifa.in_valid = 1'b0; ifa.in_sof = 1'b0; ifa.in_re = '0; ifa.in_im = '0;
    ifb.in_valid = 1'b0; ifb.in_sof = 1'b0; ifb.in_re = '0; ifb.in_im = '0;
    model_reset();

    // reset
    repeat (3) @(negedge clk);
    check_zero("in_reset");
    rst_n = 1'b1;
    for (int n = 0; n < 10; n++) begin
      step(1'b0, 1'b0, '0, '0);
      check_zero("post_reset");
    end

    // basic butterfly
    cap = 1'b1; cap_q.delete();
    basic_pair(1'b0);
    cap = 1'b0;
    check_basic_capture("basic");

    // scaling on B: (3,0) then (-3,0)
    re_s = '{3, 0, -3, 0}; im_s = '{3, 0, -3, 0}; sof_s = '{1, 0, 1, 0};
    send_seq(re_s, im_s, sof_s, 1'b0);
    re_s = '{0, 0, 0, 0}; im_s = '{0, 0, 0, 0}; sof_s = '{1, 0, 1, 0};
    send_seq(re_s, im_s, sof_s, 1'b0);

    // overflow wrap on A
    pulse_reset(1'b0);
    re_s.delete(); im_s.delete(); sof_s.delete();
    for (int n = 0; n < 16; n++) begin
      re_s.push_back(n == 0 ? 65535 : (n == 4 ? 1 : 0));
      im_s.push_back(n == 0 ? -65536 : (n == 4 ? 1 : 0));
      sof_s.push_back(n == 0 || n == 8);
    end
    cap = 1'b1; cap_q.delete();
    send_seq(re_s, im_s, sof_s, 1'b0);
    cap = 1'b0;
    check("ovf_count", 64'(cap_q.size()), 64'(12));
    if (cap_q.size() >= 5) begin
      g = W'(-65536);
      check("ovf_sum", 64'(cap_q[0]), 64'(g));
      g = W'(65534);
      check("ovf_diff", 64'(cap_q[4]), 64'(g));
    end

    // stall equivalence
    pulse_reset(1'b0);
    cap = 1'b1; cap_q.delete();
    basic_pair(1'b1);
    cap = 1'b0;
    check_basic_capture("stall");

    // misaligned sof at cnt=3, then realigned frame and drain
    re_s.delete(); im_s.delete(); sof_s.delete();
    for (int n = 0; n < 26; n++) begin
      re_s.push_back(n * 7 - 40);
      im_s.push_back(100 - n * 3);
      sof_s.push_back(n == 0 || n == 11 || n == 19);
    end
    send_seq(re_s, im_s, sof_s, 1'b0);

    // random frames with random stalls
    for (int f = 0; f < 8; f++) begin
      re_s.delete(); im_s.delete(); sof_s.delete();
      for (int n = 0; n < 8; n++) begin
        re_s.push_back(sx(W'($urandom)));
        im_s.push_back(sx(W'($urandom)));
        sof_s.push_back(n == 0);
      end
      send_seq(re_s, im_s, sof_s, 1'b1);
    end

    // asynchronous reset mid-frame, then a clean frame and drain
    re_s = '{5, -6, 7, -8, 9}; im_s = '{1, 2, 3, 4, 5}; sof_s = '{1, 0, 0, 0, 0};
    send_seq(re_s, im_s, sof_s, 1'b0);
    pulse_reset(1'b1);
    basic_pair(1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/sdf_r2_stage.md
Name: sdf_r2_stage

Overview:
- Parametrised radix-2 single-path delay-feedback (SDF) butterfly stage for the pipelined FFT.
- Contains a delay line of configurable depth, a sample counter that derives the butterfly phase internally, valid-qualified streaming with stalls, frame-sync input and output, and an optional divide-by-2 scaling mode.
- Cascading log2(N) instances, with twiddle multipliers between stages, forms an N-point DIF FFT.

Parameters:
- WIDTH, 17: two's-complement width of each real and imaginary sample.
- DEPTH, 32: delay-line length; must be a power of 2, at least 1. Stage span is 2*DEPTH.
- SCALE, 0: 1 = each butterfly result is halved with rounding; 0 = full-scale wrap arithmetic.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample present this cycle.
- in_sof  in  1  start of frame; qualified by in_valid.
- in_re  in  WIDTH  input real part.
- in_im  in  WIDTH  input imaginary part.
- out_valid  out  1  output sample valid.
- out_sof  out  1  first output of a frame.
- out_re  out  WIDTH  output real part.
- out_im  out  WIDTH  output imaginary part.

Behaviour:
- Reset: out_valid, out_sof, out_re and out_im are 0; counter is 0; primed flag is 0; delay-line contents are 0. Reset is asynchronous and may assert at any time, mid-frame included; every state returns to reset values.
- Accepting samples: a sample is accepted on each clk edge with in_valid=1. Only accepted samples advance the counter and the delay line. With in_valid=0, all internal state and out_re/out_im hold, and out_valid=0 and out_sof=0 on the next cycle.
- Counter: cnt is log2(DEPTH)+1 bits and increments by 1 per accepted sample, wrapping from 2*DEPTH-1 to 0. phase = cnt MSB; idx = the remaining bits.
- in_sof with in_valid: the sample is treated as cnt=0, and cnt becomes 1 afterwards. If cnt was not already 0 (misaligned sof), primed is cleared.
- Delay line: D denotes the entry written DEPTH accepted samples earlier.
- Phase 0: the input x is written into the delay line; the output is D (the previous frame's difference); no arithmetic.
- Phase 1, sum: out = D + x.
- Phase 1, difference: D - x is written into the delay line.
- Arithmetic with SCALE=0: WIDTH-bit sum and difference, wrapping on overflow, no saturation.
- Arithmetic with SCALE=1: sum and difference are computed at WIDTH+1 bits, then r = (v + 1) >>> 1 (arithmetic shift, round half up) and truncated to WIDTH bits. Phase-0 passthrough data is not re-scaled; it was scaled when written.
- Latency: the output is registered, one clk after the accepted sample.
- primed flag: set on the first accepted phase-1 sample.
- out_valid: equals the registered (in_valid and (primed or phase==1)). Phase-0 outputs before the first phase 1 are therefore suppressed.
- out_sof: asserted with the output produced from the phase-1, idx-0 sample.
- Continuous frames: with back-to-back frames the output stream is continuous. The phase-0 outputs of frame k+1 carry the differences of frame k.
- Simultaneous events: in_sof together with the wrap to cnt=0 is a no-op realignment. Reset overrides everything.
- Draining the last differences: the last frame's differences need DEPTH further accepted samples (e.g. zeros) to drain.

Test Plan:
1. Reset check: hold rst_n low, then release with in_valid=0 -> all outputs 0; out_valid stays 0 for 10 cycles.
2. Basic butterfly: DEPTH=4, SCALE=0; send real 1..8 (sof on 1), then 0..0 with sof.
   - Output re after samples 5..8: 6, 8, 10, 12, with out_sof on 6, one cycle after sample 5.
   - Next four outputs: -4, -4, -4, -4.
   - No valid output during samples 1..4.
3. Scaling: SCALE=1, DEPTH=1; input pairs (3,0) and (-3,0).
   - Pair (3,0): sum 2, difference 2.
   - Pair (-3,0): sum -1, difference -1.
   - Imaginary part uses the same rule.
4. Overflow wrap: SCALE=0, WIDTH=17; D=65535, x=1 -> sum -65536, difference 65534.
5. Stall equivalence: repeat test 2 with in_valid randomly low 50% of cycles -> identical valid output sequence. Data and state hold during gaps.
6. Misalignment and reset:
   - Assert in_sof at cnt=3 -> primed cleared; next 4 samples give out_valid=0; realigned frame outputs are correct.
   - Assert rst_n low mid-frame -> outputs 0 immediately (asynchronous); the following frame is correct.
